// File: rtl/intr_ctrl.sv
// External interrupt controller: synchronises request lines, latches edge/level pendings,
// applies mask and fixed lowest-index priority, and handshakes with the control unit.
module intr_ctrl #(
    parameter int                    NUM_IRQ   = 8,
    parameter int                    ID_W      = 3,
    parameter logic [NUM_IRQ-1:0]    EDGE_MASK = {NUM_IRQ{1'b1}}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_IRQ-1:0]   irq_in,
    input  logic                 mask_wen,
    input  logic [NUM_IRQ-1:0]   mask_wdata,
    input  logic [NUM_IRQ-1:0]   pend_clr,
    input  logic                 cu_intr,
    input  logic                 eret_done,
    output logic                 intr,
    output logic [ID_W-1:0]      intr_id,
    output logic [NUM_IRQ-1:0]   pending,
    output logic [NUM_IRQ-1:0]   mask,
    output logic                 in_service
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_IRQ-1:0]   s1_q, s2_q, s3_q;
    logic [NUM_IRQ-1:0]   pending_q, pending_d;
    logic [NUM_IRQ-1:0]   mask_q, mask_d;
    logic [NUM_IRQ-1:0]   eligible;
    logic [NUM_IRQ-1:0]   edge_set;
    logic [NUM_IRQ-1:0]   edge_keep;
    logic [NUM_IRQ-1:0]   accept_clr;
    logic                 intr_q, intr_d;
    logic [ID_W-1:0]      intr_id_q, intr_id_d;
    logic                 in_service_q, in_service_d;
    logic [ID_W-1:0]      winner;
    logic                 any_eligible;
    logic                 accept;

    // Two-flop synchroniser (s1, s2) plus one history flop (s3) for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= irq_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign edge_set = s2_q & ~s3_q & EDGE_MASK;

    // Acceptance clears only the line whose id was frozen at the handshake.
    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_accept_clr
            assign accept_clr[gi] = accept && (intr_id_q == ID_W'(gi));
        end
    endgenerate

    // Set beats clear so a fresh edge is never lost; level lines simply track s2.
    assign edge_keep = pending_q & ~(pend_clr | accept_clr);
    assign pending_d = (EDGE_MASK & (edge_set | edge_keep)) | (~EDGE_MASK & s2_q);
    assign mask_d    = mask_wen ? mask_wdata : mask_q;
    assign eligible  = pending_q & ~mask_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            mask_q    <= '1;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
        end
    end

    // Fixed priority: scan downwards so the lowest eligible index is the last written.
    always_comb begin
        winner       = '0;
        any_eligible = |eligible;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        intr_d       = 1'b0;
        intr_id_d    = intr_id_q;
        in_service_d = 1'b0;
        accept       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_eligible) begin
                    state_d   = REQ;
                    intr_d    = 1'b1;
                    intr_id_d = winner;
                end
            end
            REQ: begin
                // An acceptance is honoured even if the line vanished in the same cycle.
                if (cu_intr) begin
                    state_d      = SERVICE;
                    in_service_d = 1'b1;
                    accept       = 1'b1;
                end else if (!any_eligible) begin
                    state_d = IDLE;
                end else begin
                    intr_d    = 1'b1;
                    intr_id_d = winner;
                end
            end
            SERVICE: begin
                if (eret_done) begin
                    state_d = IDLE;
                end else begin
                    in_service_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            intr_q       <= 1'b0;
            intr_id_q    <= '0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            intr_q       <= intr_d;
            intr_id_q    <= intr_id_d;
            in_service_q <= in_service_d;
        end
    end

    assign intr       = intr_q;
    assign intr_id    = intr_id_q;
    assign pending    = pending_q;
    assign mask       = mask_q;
    assign in_service = in_service_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed, table-driven bench for intr_ctrl (line 2 configured as level-triggered).
module tb_intr_ctrl;

    localparam int NUM_IRQ = 8;
    localparam int ID_W    = 3;

    logic               clk;
    logic               rst;
    logic [7:0]         irq_in;
    logic               mask_wen;
    logic [7:0]         mask_wdata;
    logic [7:0]         pend_clr;
    logic               cu_intr;
    logic               eret_done;
    logic               intr;
    logic [2:0]         intr_id;
    logic [7:0]         pending;
    logic [7:0]         mask;
    logic               in_service;

    intr_ctrl #(
        .NUM_IRQ   (NUM_IRQ),
        .ID_W      (ID_W),
        .EDGE_MASK (8'hFB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .mask_wen   (mask_wen),
        .mask_wdata (mask_wdata),
        .pend_clr   (pend_clr),
        .cu_intr    (cu_intr),
        .eret_done  (eret_done),
        .intr       (intr),
        .intr_id    (intr_id),
        .pending    (pending),
        .mask       (mask),
        .in_service (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] irq;
        logic       mwen;
        logic [7:0] mwd;
        logic [7:0] clr;
        logic       cu;
        logic       eret;
        logic       e_intr;
        logic [2:0] e_id;
        logic [7:0] e_pend;
        logic [7:0] e_mask;
        logic       e_svc;
    } vec_t;

    vec_t vecs [64];
    int   nvec;
    int   applied;
    int   miscompares;

    function automatic vec_t mk(input logic [7:0] irq, input logic mwen, input logic [7:0] mwd,
                                input logic [7:0] clr, input logic cu, input logic eret,
                                input logic e_intr, input logic [2:0] e_id, input logic [7:0] e_pend,
                                input logic [7:0] e_mask, input logic e_svc);
        vec_t v;
        v.irq = irq; v.mwen = mwen; v.mwd = mwd; v.clr = clr; v.cu = cu; v.eret = eret;
        v.e_intr = e_intr; v.e_id = e_id; v.e_pend = e_pend; v.e_mask = e_mask; v.e_svc = e_svc;
        return v;
    endfunction

    task automatic add(input vec_t v);
        vecs[nvec] = v;
        nvec++;
    endtask

    task automatic check(input string name, input logic x_intr, input logic [2:0] x_id,
                         input logic [7:0] x_pend, input logic [7:0] x_mask, input logic x_svc);
        applied++;
        if (intr !== x_intr || intr_id !== x_id || pending !== x_pend ||
            mask !== x_mask || in_service !== x_svc) begin
            miscompares++;
            $display("FAIL %s: got intr=%b id=%0d pend=%h mask=%h svc=%b, want intr=%b id=%0d pend=%h mask=%h svc=%b",
                     name, intr, intr_id, pending, mask, in_service,
                     x_intr, x_id, x_pend, x_mask, x_svc);
        end else begin
            $display("ok   %s: intr=%b id=%0d pend=%h mask=%h svc=%b",
                     name, intr, intr_id, pending, mask, in_service);
        end
    endtask

    task automatic idle_inputs();
        irq_in = '0; mask_wen = 0; mask_wdata = '0; pend_clr = '0; cu_intr = 0; eret_done = 0;
    endtask

    initial begin
        int cnt;
        nvec = 0; applied = 0; miscompares = 0;
        //   irq    wen mwd    clr    cu eret | intr id pend   mask   svc
        // edge line 5 end to end, plus ignored cu/eret in IDLE
        add(mk(8'h00,1,8'h00,8'h00,0,0, 0,3'd0,8'h00,8'h00,0));
        add(mk(8'h20,0,8'h00,8'h00,0,0, 0,3'd0,8'h00,8'h00,0));
        add(mk(8'h00,0,8'h00,8'h00,0,0, 0,3'd0,8'h00,8'h00,0));
        add(mk(8'h00,0,8'h00,8'h00,0,0, 0,3'd0,8'h20,8'h00,0));
        add(mk(8'h00,0,8'h00,8'h00,0,0, 1,3'd5,8'h20,8'h00,0));
        add(mk(8'h00,0,8'h00,8'h00,1,0, 0,3'd5,8'h00,8'h00,1));
        add(mk(8'h00,0,8'h00,8'h00,0,1, 0,3'd5,8'h00,8'h00,0));
        add(mk(8'h00,0,8'h00,8'h00,1,1, 0,3'd5,8'h00,8'h00,0));
        // line 6 pre-empted by line 1 before acceptance
        add(mk(8'h40,0,8'h00,8'h00,0,0, 0,3'd5,8'h00,8'h00,0));
        add(mk(8'h00,0,8'h00,8'h00,0,0, 0,3'd5,8'h00,8'h00,0));
        add(mk(8'h00,0,8'h00,8'h00,0,0, 0,3'd5,8'h40,8'h00,0));
        add(mk(8'h02,0,8'h00,8'h00,0,0, 1,3'd6,8'h40,8'h00,0));
        add(mk(8'h00,0,8'h00,8'h00,0,0, 1,3'd6,8'h40,8'h00,0));
        add(mk(8'h00,0,8'h00,8'h00,0,0, 1,3'd6,8'h42,8'h00,0));
        add(mk(8'h00,0,8'h00,8'h00,0,0, 1,3'd1,8'h42,8'h00,0));
        add(mk(8'h00,0,8'h00,8'h00,1,0, 0,3'd1,8'h40,8'h00,1));
        add(mk(8'h00,0,8'h00,8'h00,0,1, 0,3'd1,8'h40,8'h00,0));
        add(mk(8'h00,0,8'h00,8'h00,0,0, 1,3'd6,8'h40,8'h00,0));
        add(mk(8'h00,0,8'h00,8'h00,1,0, 0,3'd6,8'h00,8'h00,1));
        add(mk(8'h00,0,8'h00,8'h00,0,1, 0,3'd6,8'h00,8'h00,0));
        // level line 2 drops before acceptance
        add(mk(8'h04,0,8'h00,8'h00,0,0, 0,3'd6,8'h00,8'h00,0));
        add(mk(8'h04,0,8'h00,8'h00,0,0, 0,3'd6,8'h00,8'h00,0));
        add(mk(8'h04,0,8'h00,8'h00,0,0, 0,3'd6,8'h04,8'h00,0));
        add(mk(8'h00,0,8'h00,8'h00,0,0, 1,3'd2,8'h04,8'h00,0));
        add(mk(8'h00,0,8'h00,8'h00,0,0, 1,3'd2,8'h04,8'h00,0));
        add(mk(8'h00,0,8'h00,8'h00,0,0, 1,3'd2,8'h00,8'h00,0));
        add(mk(8'h00,0,8'h00,8'h00,0,0, 0,3'd2,8'h00,8'h00,0));
        add(mk(8'h00,0,8'h00,8'h00,0,0, 0,3'd2,8'h00,8'h00,0));
        // enter service on line 0, edge on line 3 during service
        add(mk(8'h01,0,8'h00,8'h00,0,0, 0,3'd2,8'h00,8'h00,0));
        add(mk(8'h00,0,8'h00,8'h00,0,0, 0,3'd2,8'h00,8'h00,0));
        add(mk(8'h00,0,8'h00,8'h00,0,0, 0,3'd2,8'h01,8'h00,0));
        add(mk(8'h00,0,8'h00,8'h00,0,0, 1,3'd0,8'h01,8'h00,0));
        add(mk(8'h00,0,8'h00,8'h00,1,0, 0,3'd0,8'h00,8'h00,1));
        add(mk(8'h08,0,8'h00,8'h00,0,0, 0,3'd0,8'h00,8'h00,1));
        add(mk(8'h00,0,8'h00,8'h00,0,0, 0,3'd0,8'h00,8'h00,1));
        add(mk(8'h00,0,8'h00,8'h00,0,0, 0,3'd0,8'h08,8'h00,1));
        add(mk(8'h00,0,8'h00,8'h00,1,0, 0,3'd0,8'h08,8'h00,1));
        add(mk(8'h00,0,8'h00,8'h00,0,1, 0,3'd0,8'h08,8'h00,0));
        add(mk(8'h00,0,8'h00,8'h00,0,0, 1,3'd3,8'h08,8'h00,0));
        add(mk(8'h00,0,8'h00,8'h00,1,0, 0,3'd3,8'h00,8'h00,1));
        add(mk(8'h00,0,8'h00,8'h00,0,1, 0,3'd3,8'h00,8'h00,0));
        // masked line 4, then unmask; pend_clr withdraws the request
        add(mk(8'h00,1,8'h10,8'h00,0,0, 0,3'd3,8'h00,8'h10,0));
        add(mk(8'h10,0,8'h00,8'h00,0,0, 0,3'd3,8'h00,8'h10,0));
        add(mk(8'h00,0,8'h00,8'h00,0,0, 0,3'd3,8'h00,8'h10,0));
        add(mk(8'h00,0,8'h00,8'h00,0,0, 0,3'd3,8'h10,8'h10,0));
        add(mk(8'h00,0,8'h00,8'h00,0,0, 0,3'd3,8'h10,8'h10,0));
        add(mk(8'h00,0,8'h00,8'h00,0,0, 0,3'd3,8'h10,8'h10,0));
        add(mk(8'h00,1,8'h00,8'h00,0,0, 0,3'd3,8'h10,8'h00,0));
        add(mk(8'h00,0,8'h00,8'h00,0,0, 1,3'd4,8'h10,8'h00,0));
        add(mk(8'h00,0,8'h00,8'h10,0,0, 1,3'd4,8'h00,8'h00,0));
        add(mk(8'h00,0,8'h00,8'h00,0,0, 0,3'd4,8'h00,8'h00,0));
        // same-cycle clear and new edge on masked line 0: set wins
        add(mk(8'h00,1,8'h01,8'h00,0,0, 0,3'd4,8'h00,8'h01,0));
        add(mk(8'h01,0,8'h00,8'h00,0,0, 0,3'd4,8'h00,8'h01,0));
        add(mk(8'h00,0,8'h00,8'h00,0,0, 0,3'd4,8'h00,8'h01,0));
        add(mk(8'h00,0,8'h00,8'h00,0,0, 0,3'd4,8'h01,8'h01,0));
        add(mk(8'h01,0,8'h00,8'h00,0,0, 0,3'd4,8'h01,8'h01,0));
        add(mk(8'h00,0,8'h00,8'h00,0,0, 0,3'd4,8'h01,8'h01,0));
        add(mk(8'h00,0,8'h00,8'h01,0,0, 0,3'd4,8'h01,8'h01,0));
        add(mk(8'h00,0,8'h00,8'h01,0,0, 0,3'd4,8'h00,8'h01,0));

        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("reset", 0, 3'd0, 8'h00, 8'hFF, 0);
        rst = 1'b0;

        for (int k = 0; k < nvec; k++) begin
            irq_in     = vecs[k].irq;
            mask_wen   = vecs[k].mwen;
            mask_wdata = vecs[k].mwd;
            pend_clr   = vecs[k].clr;
            cu_intr    = vecs[k].cu;
            eret_done  = vecs[k].eret;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", k), vecs[k].e_intr, vecs[k].e_id,
                  vecs[k].e_pend, vecs[k].e_mask, vecs[k].e_svc);
        end

        // Line 7: request latency is three edges after the capturing edge.
        idle_inputs();
        irq_in = 8'h80;
        @(posedge clk);
        #1;
        irq_in = 8'h00;
        cnt = 0;
        while (intr !== 1'b1 && cnt < 8) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        applied++;
        if (cnt != 3) begin
            miscompares++;
            $display("FAIL latency7: got %0d edges, want 3", cnt);
        end else begin
            $display("ok   latency7: %0d edges", cnt);
        end
        check("req7", 1, 3'd7, 8'h80, 8'h01, 0);

        cu_intr = 1'b1;
        @(posedge clk);
        #1;
        cu_intr = 1'b0;
        check("svc7", 0, 3'd7, 8'h00, 8'h01, 1);

        // Mid-cycle reset while in service must act without a clock edge.
        irq_in = 8'h02;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", 0, 3'd0, 8'h00, 8'hFF, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_masked", 0, 3'd0, 8'h02, 8'hFF, 0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- External interrupt controller that sits directly upstream of the pipeline control unit.
- Synchronises and latches NUM_IRQ external request lines, applies a software mask and fixed priority, and presents a single `intr` request with the winning line number.
- Consumes the control unit's `cu_intr` acceptance pulse and holds off further requests until the handler's ERET retires.

Parameters:
- NUM_IRQ, 8: number of external interrupt lines.
- ID_W, 3: width of the line-number output; must satisfy 2^ID_W >= NUM_IRQ.
- EDGE_MASK, 8'hFF: per-line trigger type. 1 = rising-edge triggered, 0 = level triggered (active high).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- irq_in  input  NUM_IRQ  raw external request lines, asynchronous to clk.
- mask_wen  input  1  write strobe for the mask register.
- mask_wdata  input  NUM_IRQ  new mask value; bit = 1 disables that line.
- pend_clr  input  NUM_IRQ  software clear for edge-pending bits, one cycle per bit.
- cu_intr  input  1  pulse from the control unit: interrupt accepted this cycle.
- eret_done  input  1  pulse: ERET has committed, handler finished.
- intr  output  1  interrupt request to the control unit.
- intr_id  output  ID_W  number of the requesting/accepted line.
- pending  output  NUM_IRQ  raw pending vector, before masking.
- mask  output  NUM_IRQ  current mask register.
- in_service  output  1  high while a handler is running.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-service):
  - sync flops, edge-history flops, pending, intr, intr_id, in_service all 0;
  - mask all ones;
  - state IDLE.
- Synchroniser: 2-flop synchroniser per line gives s2. A third flop holds s2_d for edge detection.
- Edge lines: pending bit sets when s2 & ~s2_d. It clears on pend_clr[i] or on acceptance of line i. A set condition in the same cycle as a clear wins, so no edge is lost.
- Level lines: pending[i] <= s2[i] every cycle. pend_clr and acceptance have no effect on these bits.
- Latency: an irq_in rising edge meeting setup before clk edge N gives pending=1 after edge N+2 and intr=1 after edge N+3.
- Mask: mask <= mask_wdata on mask_wen; the new value is effective the next cycle. eligible = pending & ~mask.
- Priority: lowest index wins. The winner's index is zero-extended to ID_W.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if eligible != 0, go to REQ and register intr_id = winner.
  - REQ: intr = 1. Each cycle, intr_id re-registers to the current winner, so a higher-priority arrival pre-empts before acceptance.
    - If eligible == 0 (level dropped, masked, or cleared): return to IDLE and drop intr the next cycle.
    - If cu_intr = 1: go to SERVICE, freeze intr_id at its current value, clear that line's edge-pending bit, intr = 0 from the next cycle.
  - SERVICE: intr = 0, in_service = 1. New pendings still latch. When eret_done = 1, go to IDLE; a new request may assert 2 cycles after eret_done.
  - cu_intr outside REQ is ignored. eret_done outside SERVICE is ignored.
- Registered outputs: intr, intr_id and in_service are registered with no combinational path from inputs. pending and mask are register outputs.
- Pause: `pause` does not reach this block. The control unit does not pulse cu_intr while paused, so intr stays asserted across stalls.

Test Plan:
- Reset, write mask=8'h00, pulse irq_in[5] (edge) for 1 cycle -> pending[5]=1 at N+2, intr=1, intr_id=5 at N+3; cu_intr -> intr=0, in_service=1, pending[5]=0.
- Raise irq_in[6] while REQ for line 6, then irq_in[1] before acceptance -> intr_id changes 6 to 1; cu_intr -> accepted id = 1; pending[6] still 1.
- Level line 2 (EDGE_MASK bit 2 = 0) asserted, then deasserted before cu_intr -> intr falls, FSM returns to IDLE, intr_id not frozen.
- In SERVICE, assert edge irq 3 -> no intr; pulse eret_done -> intr=1, intr_id=3 two cycles later.
- Line 4 pending with mask[4]=1 -> intr stays 0; clear the mask -> intr=1 one cycle after the write.
- Same-cycle pend_clr[0] and new edge on line 0 -> pending[0] stays 1. Assert rst during SERVICE -> all outputs 0, mask=all ones, immediately.
